// File: rtl/uart_pkg.sv
// Shared UART definitions: default frame/oversampling constants, RX state
// encodings and a small majority-vote helper.
package uart_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 8;
  localparam int unsigned DEF_OVERSAMPLE = 16;

  localparam logic [1:0] RX_IDLE  = 2'b00;
  localparam logic [1:0] RX_START = 2'b01;
  localparam logic [1:0] RX_DATA  = 2'b10;
  localparam logic [1:0] RX_STOP  = 2'b11;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the async serial line plus a falling-edge
// detector on the synchronized value. All flops reset to the idle level (1).
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic rx_in,
  output logic rx_s,
  output logic fall
);

  logic meta;
  logic rx_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b1;
      rx_s <= 1'b1;
      rx_d <= 1'b1;
    end else begin
      meta <= rx_in;
      rx_s <= meta;
      rx_d <= rx_s;
    end
  end

  assign fall = rx_d & ~rx_s;

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receive stage with 16x oversampling, start-bit validation and
// stop-bit checking. Define UART_RX_MAJORITY_EN for 3-sample majority decisions.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned OVERSAMPLE = DEF_OVERSAMPLE
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_en,
  input  logic                  sample_tick,
  input  logic                  rx_in,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  valid,
  output logic                  frame_err,
  output logic                  busy
);

  localparam int unsigned TW = $clog2(OVERSAMPLE);
  localparam int unsigned BW = $clog2(DATA_WIDTH + 1);
  localparam logic [TW-1:0] MID_TICK  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] LAST_TICK = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_WIDTH - 1);

  logic                  rx_s;
  logic                  fall;
  logic [1:0]            state;
  logic [TW-1:0]         tick_cnt;
  logic [BW-1:0]         bit_cnt;
  logic [DATA_WIDTH-1:0] shreg;
  logic                  bit_val;

  uart_rx_sync u_sync (
    .clk   (clk),
    .rst   (rst),
    .rx_in (rx_in),
    .rx_s  (rx_s),
    .fall  (fall)
  );

`ifdef UART_RX_MAJORITY_EN
  // History of the two previous tick samples; the vote includes the current one.
  logic s1, s2;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
    end else if (sample_tick) begin
      s1 <= rx_s;
      s2 <= s1;
    end
  end

  assign bit_val = maj3(rx_s, s1, s2);
`else
  assign bit_val = rx_s;
`endif

  assign busy = (state != RX_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RX_IDLE;
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      valid     <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        RX_IDLE: begin
          if (rx_en && fall) begin
            state    <= RX_START;
            tick_cnt <= '0;
          end
        end
        RX_START: begin
          if (sample_tick) begin
            if (tick_cnt == MID_TICK) begin
              if (bit_val) begin
                state <= RX_IDLE;
              end else begin
                state    <= RX_DATA;
                tick_cnt <= '0;
                bit_cnt  <= '0;
              end
            end else begin
              tick_cnt <= tick_cnt + TW'(1);
            end
          end
        end
        RX_DATA: begin
          if (sample_tick) begin
            tick_cnt <= tick_cnt + TW'(1);
            if (tick_cnt == LAST_TICK) begin
              shreg   <= {bit_val, shreg[DATA_WIDTH-1:1]};
              bit_cnt <= bit_cnt + BW'(1);
              if (bit_cnt == LAST_BIT) begin
                state <= RX_STOP;
              end
            end
          end
        end
        RX_STOP: begin
          if (sample_tick) begin
            tick_cnt <= tick_cnt + TW'(1);
            if (tick_cnt == LAST_TICK) begin
              state <= RX_IDLE;
              if (bit_val) begin
                data  <= shreg;
                valid <= 1'b1;
              end else begin
                frame_err <= 1'b1;
              end
            end
          end
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Directed testbench for uart_receiver: drives 8N1 frames one oversample tick
// at a time and checks bytes, pulses and busy behaviour against hand values.
module tb_uart_receiver;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_en = 1'b1;
  logic       sample_tick = 1'b0;
  logic       rx_in = 1'b1;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       busy;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  uart_receiver #(.DATA_WIDTH(8), .OVERSAMPLE(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_en       (rx_en),
    .sample_tick (sample_tick),
    .rx_in       (rx_in),
    .data        (data),
    .valid       (valid),
    .frame_err   (frame_err),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // Monitor: counts pulses, logs received bytes and busy run lengths.
  int unsigned valid_cnt = 0;
  int unsigned ferr_cnt = 0;
  int unsigned both_cnt = 0;
  int unsigned wide_cnt = 0;
  int unsigned busy_bad = 0;
  int unsigned busy_run = 0;
  int unsigned busy_last = 0;
  logic        prev_pulse = 1'b0;
  logic [7:0]  rx_log [0:63];

  always @(negedge clk) begin
    if (valid) begin
      rx_log[valid_cnt[5:0]] <= data;
      valid_cnt <= valid_cnt + 1;
    end
    if (frame_err) ferr_cnt <= ferr_cnt + 1;
    if (valid && frame_err) both_cnt <= both_cnt + 1;
    if ((valid || frame_err) && prev_pulse) wide_cnt <= wide_cnt + 1;
    if ((valid || frame_err) && busy) busy_bad <= busy_bad + 1;
    prev_pulse <= valid | frame_err;
    if (busy) begin
      busy_run <= busy_run + 1;
    end else if (busy_run != 0) begin
      busy_last <= busy_run;
      busy_run  <= 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // One oversample period (4 clk) with the line at v; the tick lands at its end.
  task automatic tick(input logic v);
    rx_in = v;
    repeat (3) @(negedge clk);
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b1);
  endtask

  // 160 ticks per frame: start 0..15, bit k 16(k+1).., stop 144..159.
  task automatic send_frame(input logic [7:0] b, input logic stop_v,
                            input int glitch_at, input int rst_at, input int en_off_at);
    logic v;
    for (int i = 0; i < 160; i++) begin
      if (i < 16)       v = 1'b0;
      else if (i < 144) v = b[(i - 16) / 16];
      else              v = stop_v;
      if (i == glitch_at) v = ~v;
      if (i == en_off_at) rx_en = 1'b0;
      if (i == rst_at) begin
        rx_in = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        return;
      end
      tick(v);
    end
  endtask

  int unsigned v0, f0;

  initial begin
    repeat (4) @(negedge clk);
    check("rst_data", data, 32'h0);
    check("rst_valid", valid, 32'h0);
    check("rst_ferr", frame_err, 32'h0);
    check("rst_busy", busy, 32'h0);
    rst = 1'b0;
    idle(4);

    // Clean frame 0xA5
    v0 = valid_cnt; f0 = ferr_cnt;
    send_frame(8'hA5, 1'b1, -1, -1, -1);
    check("a5_valid_cnt", valid_cnt - v0, 32'd1);
    check("a5_ferr_cnt", ferr_cnt - f0, 32'd0);
    check("a5_data", data, 32'hA5);
    check("a5_busy_after", busy, 32'h0);
    idle(4);

    // 4-tick low glitch: false start
    v0 = valid_cnt; f0 = ferr_cnt;
    for (int i = 0; i < 4; i++) tick(1'b0);
    idle(30);
    check("glitch_valid_cnt", valid_cnt - v0, 32'd0);
    check("glitch_ferr_cnt", ferr_cnt - f0, 32'd0);
    check("glitch_busy_seen", busy_last > 0, 32'd1);
    check("glitch_busy_len_le32", busy_last <= 32, 32'd1);
    check("glitch_busy_idle", busy, 32'h0);

    // 0x3C with a low stop bit
    v0 = valid_cnt; f0 = ferr_cnt;
    send_frame(8'h3C, 1'b0, -1, -1, -1);
    idle(4);
    check("ferr_ferr_cnt", ferr_cnt - f0, 32'd1);
    check("ferr_valid_cnt", valid_cnt - v0, 32'd0);
    check("ferr_data_kept", data, 32'hA5);

    // Back-to-back 0x00 then 0xFF
    v0 = valid_cnt;
    send_frame(8'h00, 1'b1, -1, -1, -1);
    send_frame(8'hFF, 1'b1, -1, -1, -1);
    check("b2b_valid_cnt", valid_cnt - v0, 32'd2);
    check("b2b_first", rx_log[v0[5:0]], 32'h00);
    check("b2b_second", rx_log[v0[5:0] + 6'd1], 32'hFF);
    idle(4);

    // Reset during bit 3 of 0x81, then a full 0x42
    v0 = valid_cnt; f0 = ferr_cnt;
    send_frame(8'h81, 1'b1, -1, 16 * 4 + 3, -1);
    check("rst_mid_busy", busy, 32'h0);
    check("rst_mid_data", data, 32'h0);
    idle(180);
    check("rst_mid_no_valid", valid_cnt - v0, 32'd0);
    check("rst_mid_no_ferr", ferr_cnt - f0, 32'd0);
    send_frame(8'h42, 1'b1, -1, -1, -1);
    check("post_rst_valid_cnt", valid_cnt - v0, 32'd1);
    check("post_rst_data", data, 32'h42);
    idle(4);

    // rx_en dropped mid-frame completes; next frame is ignored
    v0 = valid_cnt;
    send_frame(8'h5A, 1'b1, -1, -1, 40);
    check("en_off_mid_valid", valid_cnt - v0, 32'd1);
    check("en_off_mid_data", data, 32'h5A);
    idle(4);
    send_frame(8'h33, 1'b1, -1, -1, -1);
    check("en_off_ignored", valid_cnt - v0, 32'd1);
    check("en_off_data_kept", data, 32'h5A);
    rx_en = 1'b1;
    idle(4);

    // One-tick glitch at the bit-0 decision tick of 0xFF
    v0 = valid_cnt;
    send_frame(8'hFF, 1'b1, 16 + 7, -1, -1);
    check("maj_valid_cnt", valid_cnt - v0, 32'd1);
`ifdef UART_RX_MAJORITY_EN
    check("maj_data", data, 32'hFF);
`else
    check("maj_data", data, 32'hFE);
`endif
    idle(4);

    check("never_both", both_cnt, 32'd0);
    check("pulse_width_one", wide_cnt, 32'd0);
    check("busy_low_on_pulse", busy_bad, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
